// File: rtl/mult_sched.sv
// Round-robin scheduler for two requesters sharing one shift-add multiplier; done at t+2+2*NUM_BITS.
// Requests are sampled only in IDLE and held by requesters until granted; no other backpressure.
module mult_sched #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                req1,
    input  logic [NUM_BITS-1:0] md0,
    input  logic [NUM_BITS-1:0] mr0,
    input  logic [NUM_BITS-1:0] md1,
    input  logic [NUM_BITS-1:0] mr1,
    input  logic                mr_bit,
    output logic                gnt0,
    output logic                gnt1,
    output logic [NUM_BITS-1:0] md_out,
    output logic [NUM_BITS-1:0] mr_out,
    output logic                mdld,
    output logic                mrld,
    output logic                rsclear,
    output logic                rsload,
    output logic                rsshr,
    output logic [2:0]          s,
    output logic [NUM_BITS-1:0] n,
    output logic                done,
    output logic                done_id
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [NUM_BITS-1:0] LAST = NUM_BITS'(NUM_BITS);

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic                owner;
    logic                ptr;
    logic                winner;
    logic [NUM_BITS-1:0] cnt;
    logic [NUM_BITS-1:0] cnt_inc;

    // On a tie the pointer picks; a lone request wins regardless of the pointer.
    assign winner  = (req0 && req1) ? ptr : req1;
    assign cnt_inc = cnt + NUM_BITS'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            owner <= 1'b0;
            ptr   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (req0 || req1)) begin
                owner <= winner;
                ptr   <= ~winner;
            end
            if (state == LOAD) begin
                cnt <= '0;
            end else if (state == SHIFT) begin
                cnt <= cnt_inc;
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = (req0 || req1) ? LOAD : IDLE;
            LOAD:    state_nxt = ADD;
            ADD:     state_nxt = SHIFT;
            SHIFT:   state_nxt = (cnt_inc == LAST) ? DONE : ADD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        mdld    = 1'b0;
        mrld    = 1'b0;
        rsclear = 1'b0;
        rsload  = 1'b0;
        rsshr   = 1'b0;
        done    = 1'b0;
        done_id = 1'b0;
        case (state)
            LOAD: begin
                gnt0    = ~owner;
                gnt1    = owner;
                mdld    = 1'b1;
                mrld    = 1'b1;
                rsclear = 1'b1;
            end
            ADD:   rsload = mr_bit;
            SHIFT: rsshr  = 1'b1;
            DONE: begin
                done    = 1'b1;
                done_id = owner;
            end
            default: ;
        endcase
    end

    // The operand bus always follows the latched owner, so it is stable for the whole operation.
    assign md_out = owner ? md1 : md0;
    assign mr_out = owner ? mr1 : mr0;
    assign s      = state;
    assign n      = cnt;

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: stimulus queues expected grant/rsload/done events, a monitor pops them.
module tb_mult_sched;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic          mr_bit = 1'b0;
    logic [NB-1:0] md0 = '0;
    logic [NB-1:0] mr0 = '0;
    logic [NB-1:0] md1 = '0;
    logic [NB-1:0] mr1 = '0;
    logic          gnt0, gnt1, mdld, mrld, rsclear, rsload, rsshr, done, done_id;
    logic [NB-1:0] md_out, mr_out, n;
    logic [2:0]    s;

    mult_sched #(.NUM_BITS(NB)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .md0(md0), .mr0(mr0), .md1(md1), .mr1(mr1), .mr_bit(mr_bit),
        .gnt0(gnt0), .gnt1(gnt1), .md_out(md_out), .mr_out(mr_out),
        .mdld(mdld), .mrld(mrld), .rsclear(rsclear), .rsload(rsload), .rsshr(rsshr),
        .s(s), .n(n), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 grant, 1 done, 2 rsload
        int id;
        int cyc;
        int md;
        int mr;
    } ev_t;

    ev_t      q[$];
    int       cyc = 0;
    int       t0 = -100;
    logic [3:0] mr_pat = 4'b0000;
    logic     mr_fill = 1'b0;
    int       checks = 0;
    int       failures = 0;
    logic     busy = 1'b0;
    int       shr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int id, input int c, input int md, input int mr);
        ev_t e;
        e.kind = kind;
        e.id   = id;
        e.cyc  = c;
        e.md   = md;
        e.mr   = mr;
        q.push_back(e);
    endtask

    // Grant at tg, rsload in the ADD cycles whose mr_bit is set, done nine cycles after the grant.
    task automatic push_op(input int id, input int tg, input int md, input int mr, input logic [3:0] rs);
        push_ev(0, id, tg, md, mr);
        for (int k = 0; k < 4; k++) begin
            if (rs[k]) push_ev(2, id, tg + 1 + 2 * k, 0, 0);
        end
        push_ev(1, id, tg + 9, 0, 0);
    endtask

    task automatic go_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) go_cycle();
    endtask

    // Emulates the datapath multiplier LSB: pattern bits in the ADD/SHIFT window after t0, fill elsewhere.
    always begin : mr_drv
        int off;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        off = cyc - t0;
        if (off >= 2 && off <= 9) mr_bit = mr_pat[(off - 2) / 2];
        else mr_bit = mr_fill;
    end

    always @(negedge clk) begin : mon
        ev_t e;
        int  ak;
        int  aid;
        if (gnt0 || gnt1 || done || rsload) begin
            ak  = (gnt0 || gnt1) ? 0 : (done ? 1 : 2);
            aid = (gnt0 || gnt1) ? int'(gnt1) : int'(done_id);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got kind %0d id %0d at cycle %0d, expected no event", ak, aid, cyc);
            end else begin
                e = q.pop_front();
                chk("event_kind", ak, e.kind);
                chk("event_id", aid, e.id);
                chk("event_cycle", cyc, e.cyc);
                if (ak == 0) begin
                    chk("grant_loads", {mdld, mrld, rsclear}, 3'b111);
                    chk("grant_md", md_out, e.md);
                    chk("grant_mr", mr_out, e.mr);
                    chk("grant_no_overlap", busy, 0);
                    chk("grant_onehot", {gnt0, gnt1}, gnt1 ? 2'b01 : 2'b10);
                    busy    = 1'b1;
                    shr_cnt = 0;
                end
                if (ak == 1) begin
                    chk("shift_count", shr_cnt, NB);
                    busy = 1'b0;
                end
            end
        end
        if (rsshr) shr_cnt++;
        if (rst) busy = 1'b0;
    end

    initial begin
        int t;
        // Reset held two cycles, then everything idle and zero.
        go_cycle();
        go_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", s, 0);
        chk("reset_n", n, 0);
        chk("reset_outputs", {gnt0, gnt1, md_out, mr_out, mdld, mrld, rsclear, rsload, rsshr, s, n, done, done_id}, 0);
        wait_cycles(3);
        @(negedge clk);
        chk("idle_outputs", {gnt0, gnt1, mdld, mrld, rsclear, rsload, rsshr, s, n, done, done_id}, 0);

        // Simultaneous requests after reset: requester 0 first, then 1.
        go_cycle();
        t = cyc;
        md0 = 4'd2; mr0 = 4'd7; md1 = 4'd9; mr1 = 4'd4;
        req0 = 1'b1; req1 = 1'b1;
        mr_pat = 4'b0000; mr_fill = 1'b0;
        push_op(0, t + 1, 2, 7, 4'b0000);
        push_op(1, t + 12, 9, 4, 4'b0000);
        go_cycle();
        req0 = 1'b0;
        wait_cycles(11);
        req1 = 1'b0;
        wait_cycles(11);
        chk("queue_empty_tie", q.size(), 0);

        // 3 x 5 with mr_bit 1,0,1,0 in ADD and 1 elsewhere.
        go_cycle();
        t = cyc;
        md0 = 4'd3; mr0 = 4'd5; req0 = 1'b1;
        mr_pat = 4'b0101; mr_fill = 1'b1; t0 = t;
        push_op(0, t + 1, 3, 5, 4'b0101);
        go_cycle();
        req0 = 1'b0;
        wait_cycles(11);
        mr_fill = 1'b0;
        chk("queue_empty_3x5", q.size(), 0);

        // Lone requester 1 with mr_bit low throughout.
        go_cycle();
        t = cyc;
        md1 = 4'd15; mr1 = 4'd15; req1 = 1'b1;
        mr_pat = 4'b0000; mr_fill = 1'b0;
        push_op(1, t + 1, 15, 15, 4'b0000);
        go_cycle();
        req1 = 1'b0;
        wait_cycles(11);
        chk("queue_empty_zero_mr", q.size(), 0);

        // Both held for four operations: alternate 0,1,0,1.
        go_cycle();
        t = cyc;
        md0 = 4'd4; mr0 = 4'd3; md1 = 4'd6; mr1 = 4'd2;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_op(i % 2, t + 1 + 11 * i, (i % 2) ? 6 : 4, (i % 2) ? 2 : 3, 4'b0000);
        end
        wait_cycles(34);
        req0 = 1'b0; req1 = 1'b0;
        wait_cycles(11);
        chk("queue_empty_alternate", q.size(), 0);

        // All-ones multiplier bits: rsload in every ADD cycle.
        go_cycle();
        t = cyc;
        md0 = 4'd1; mr0 = 4'd15; req0 = 1'b1;
        mr_pat = 4'b1111; mr_fill = 1'b0; t0 = t;
        push_op(0, t + 1, 1, 15, 4'b1111);
        go_cycle();
        req0 = 1'b0;
        wait_cycles(11);
        mr_pat = 4'b0000;
        chk("queue_empty_ones", q.size(), 0);

        // Reset in SHIFT with n=2: no done, pointer back to requester 0.
        go_cycle();
        t = cyc;
        md0 = 4'd5; mr0 = 4'd6; md1 = 4'd7; mr1 = 4'd3; req0 = 1'b1;
        push_ev(0, 0, t + 1, 5, 6);
        go_cycle();
        req0 = 1'b0;
        wait_cycles(6);
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        chk("abort_in_shift", s, 3);
        chk("abort_n_before", n, 2);
        go_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_state", s, 0);
        chk("abort_n", n, 0);
        chk("abort_controls", {gnt0, gnt1, mdld, mrld, rsclear, rsload, rsshr, done, done_id}, 0);
        push_op(0, t + 9, 5, 6, 4'b0000);
        push_op(1, t + 20, 7, 3, 4'b0000);
        go_cycle();
        req0 = 1'b0;
        wait_cycles(11);
        req1 = 1'b0;
        wait_cycles(11);
        chk("queue_empty_abort", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 4, giving the operand width of the shared shift-add multiplier datapath.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high; ports SHALL be named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req0, req1  input  1  requester multiply requests; held with operands stable until the matching grant.
REQ-006 md0, mr0, md1, mr1  input  NUM_BITS  multiplicand and multiplier operands per requester.
REQ-007 mr_bit  input  1  current LSB of the datapath multiplier register.
REQ-008 gnt0, gnt1  output  1  one-cycle grant pulse; operands captured this cycle.
REQ-009 md_out, mr_out  output  NUM_BITS  operand bus to datapath, muxed from the current owner.
REQ-010 mdld, mrld, rsclear, rsload, rsshr  output  1  datapath controls: load multiplicand, load multiplier, clear, load and shift running sum.
REQ-011 s  output  3  current state code; n  output  NUM_BITS  completed-iteration count.
REQ-012 done  output  1  one-cycle completion pulse; done_id  output  1  owner of the finished product.

Function
REQ-013 States SHALL be IDLE=0, LOAD=1, ADD=2, SHIFT=3, DONE=4; codes 5-7 SHALL go to IDLE on the next edge.
REQ-014 IDLE: requests SHALL be sampled only here; if any req is high, go to LOAD and latch owner, else stay.
REQ-015 Arbitration SHALL be round-robin with a 1-bit priority pointer.
- single request wins outright
- both high: pointer's requester wins
- after each grant, pointer SHALL point to the other requester
REQ-016 LOAD: assert mdld, mrld, rsclear and gnt<owner> for exactly one cycle; clear n; md_out/mr_out = owner's operands; go to ADD.
REQ-017 ADD: rsload SHALL equal mr_bit; go to SHIFT.
REQ-018 SHIFT: assert rsshr; n increments by 1; if the incremented n equals NUM_BITS go to DONE, else go to ADD.
REQ-019 DONE: assert done for one cycle with done_id = owner; go to IDLE.
REQ-020 Latency: with req sampled in IDLE at cycle t, LOAD is at t+1 and done is at t+2+2*NUM_BITS (t+10 for NUM_BITS=4), independent of operand values.
REQ-021 Outside LOAD, md_out/mr_out SHALL hold the owner's operands.
REQ-022 All control outputs SHALL be 0 in states where they are not specified above.
REQ-023 Request changes after IDLE SHALL be ignored until the next IDLE.
- dropping req mid-operation does not abort
- a request raised during DONE is arbitrated in the following IDLE cycle
REQ-024 Back-to-back: a requester holding req after its done SHALL be re-granted only per REQ-015.
- two continuous requesters alternate grants

Reset
REQ-025 rst high at a rising edge SHALL force, from any state including mid-operation, the following on the next cycle:
- s=IDLE, n=0, owner=0, pointer=req0
- all control, grant and done outputs 0
REQ-026 An aborted operation SHALL never produce done.
REQ-027 Requests still high after rst deasserts SHALL be arbitrated afresh.

Verification
REQ-028 Hold rst=1 two cycles, then release -> s=0, n=0, every output 0 and no grant while req0=req1=0.
REQ-029 req0 with md0=3, mr0=5, mr_bit driven 1,0,1,0 in ADD cycles ->
- gnt0, mdld, mrld, rsclear at t+1
- rsload 1,0,1,0 and four rsshr pulses
- done=1, done_id=0 at t+10
REQ-030 req0 and req1 rise together after reset ->
- gnt0 first, done_id=0 at t+10
- gnt1 in the LOAD following the next IDLE, done_id=1 at t+21
REQ-031 Both requests held continuously for 4 operations -> grant order 0,1,0,1 with no overlap.
REQ-032 rst asserted in SHIFT with n=2 -> next cycle s=0, n=0, no done, pointer=req0; a held req1 is then granted.
REQ-033 mr_bit=0 throughout -> rsload never asserted; done still at t+10.
